// File: rtl/motor_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// motor_ramp_ctrl: tick-paced duty ramp with dead-time direction reversal.
// Optional command watchdog enabled by defining MOTOR_CMD_WDT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module motor_ramp_ctrl #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned STEP       = 16,
  parameter int unsigned DEAD_TICKS = 50,
  parameter int unsigned WDT_TICKS  = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_power,
  output logic [9:0]  duty,
  output logic        forward,
  output logic        busy,
  output logic [1:0]  state,
  output logic        wdt_trip
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    REVERSE = 2'b10,
    DEAD    = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [9:0]  duty_q, duty_d;
  logic        forward_q, forward_d;
  logic [7:0]  dead_q, dead_d;
  logic [9:0]  tgt_mag_q, tgt_mag_d;
  logic        tgt_dir_q, tgt_dir_d;
  logic        tick;
  logic        accept;
  logic        wdt_fire;
  logic [9:0]  cmd_mag;
  logic [9:0]  goal;
  logic [10:0] up_sum;
  logic [10:0] down_gap;
  logic [9:0]  stepped;

  assign tick    = (presc_q == 24'(TICK_DIV - 1));
  assign presc_d = tick ? 24'd0 : presc_q + 24'd1;

  assign cmd_ready = enable && (state_q != DEAD);
  assign accept    = cmd_valid && cmd_ready;

  // -1024 has no positive counterpart in 10 bits; clamp it to 1023
  always_comb begin
    cmd_mag = cmd_power[9:0];
    if (cmd_power[10]) begin
      if (cmd_power[9:0] == 10'd0) cmd_mag = 10'd1023;
      else                         cmd_mag = ~cmd_power[9:0] + 10'd1;
    end
  end

`ifdef MOTOR_CMD_WDT_EN
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_trip_q, wdt_trip_d;

  always_comb begin
    wdt_cnt_d  = wdt_cnt_q;
    wdt_trip_d = wdt_trip_q;
    wdt_fire   = 1'b0;
    if (accept) begin
      wdt_cnt_d  = 16'd0;
      wdt_trip_d = 1'b0;
    end else if (tick && (wdt_cnt_q < 16'(WDT_TICKS))) begin
      wdt_cnt_d = wdt_cnt_q + 16'd1;
      if (wdt_cnt_q == 16'(WDT_TICKS - 1)) begin
        wdt_trip_d = 1'b1;
        wdt_fire   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt_q  <= 16'd0;
      wdt_trip_q <= 1'b0;
    end else begin
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_trip_q <= wdt_trip_d;
    end
  end

  assign wdt_trip = wdt_trip_q;
`else
  assign wdt_fire = 1'b0;
  assign wdt_trip = 1'b0;
`endif

  always_comb begin
    tgt_mag_d = tgt_mag_q;
    tgt_dir_d = tgt_dir_q;
    if (!enable) begin
      tgt_mag_d = 10'd0;
    end else if (accept) begin
      tgt_mag_d = cmd_mag;
      if (cmd_mag != 10'd0) tgt_dir_d = ~cmd_power[10];
    end else if (wdt_fire) begin
      tgt_mag_d = 10'd0;
    end
  end

  // Saturating one-step move toward the goal; never overshoots or wraps
  always_comb begin
    goal     = (state_q == RUN) ? tgt_mag_q : 10'd0;
    up_sum   = {1'b0, duty_q} + 11'(STEP);
    down_gap = {1'b0, duty_q} - {1'b0, goal};
    stepped  = duty_q;
    if (duty_q < goal) begin
      stepped = (up_sum > {1'b0, goal}) ? goal : up_sum[9:0];
    end else if (duty_q > goal) begin
      stepped = (down_gap <= 11'(STEP)) ? goal : duty_q - 10'(STEP);
    end
  end

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    forward_d = forward_q;
    dead_d    = dead_q;
    if (!enable) begin
      state_d = IDLE;
      duty_d  = 10'd0;
      dead_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          duty_d = 10'd0;
          if (tgt_mag_q != 10'd0) begin
            forward_d = tgt_dir_q;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (tick) duty_d = stepped;
          if ((tgt_dir_q != forward_q) && (tgt_mag_q != 10'd0)) state_d = REVERSE;
          else if ((duty_q == 10'd0) && (tgt_mag_q == 10'd0))  state_d = IDLE;
        end
        REVERSE: begin
          if (tick) duty_d = stepped;
          if (tgt_dir_q == forward_q) begin
            state_d = RUN;
          end else if (duty_q == 10'd0) begin
            state_d = DEAD;
            dead_d  = 8'd0;
          end
        end
        DEAD: begin
          duty_d = 10'd0;
          if (dead_q == 8'(DEAD_TICKS)) begin
            forward_d = ~forward_q;
            state_d   = (tgt_mag_q != 10'd0) ? RUN : IDLE;
            dead_d    = 8'd0;
          end else if (tick) begin
            dead_d = dead_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= 24'd0;
      duty_q    <= 10'd0;
      forward_q <= 1'b1;
      dead_q    <= 8'd0;
      tgt_mag_q <= 10'd0;
      tgt_dir_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      duty_q    <= duty_d;
      forward_q <= forward_d;
      dead_q    <= dead_d;
      tgt_mag_q <= tgt_mag_d;
      tgt_dir_q <= tgt_dir_d;
    end
  end

  assign duty    = duty_q;
  assign forward = forward_q;
  assign state   = state_q;
  assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_motor_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_motor_ramp_ctrl: directed test of motor_ramp_ctrl with small parameters.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_motor_ramp_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_power;
  logic [9:0]  duty;
  logic        forward;
  logic        busy;
  logic [1:0]  state;
  logic        wdt_trip;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] tb_cnt;

  motor_ramp_ctrl #(
    .TICK_DIV  (4),
    .STEP      (100),
    .DEAD_TICKS(3),
    .WDT_TICKS (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_power(cmd_power),
    .duty     (duty),
    .forward  (forward),
    .busy     (busy),
    .state    (state),
    .wdt_trip (wdt_trip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running count of cycles since reset; a tick edge follows tb_cnt==3
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 2'd0;
    else       tb_cnt <= tb_cnt + 2'd1;
  end

  task automatic wait_tick;
    int guard;
    guard = 0;
    while (tb_cnt != 2'd3 && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input int p);
    cmd_valid = 1'b1;
    cmd_power = 11'(p);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_power = 11'd0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_power = 11'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (duty !== 10'd0)   begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty); end
    n_checks++; if (forward !== 1'b1) begin n_fail++; $display("FAIL reset_fwd: got %b want 1", forward); end
    n_checks++; if (state !== 2'b00)  begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_checks++; if (wdt_trip !== 1'b0) begin n_fail++; $display("FAIL reset_wdt: got %b want 0", wdt_trip); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_forward_ramp;
    int exp_d[4] = '{100, 200, 250, 250};
    wait_tick;
    send_cmd(250);
    @(posedge clk); #1;
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL fwd_state: got %b want 01", state); end
    n_checks++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL fwd_busy: got %b want 1", busy); end
    n_checks++; if (forward !== 1'b1) begin n_fail++; $display("FAIL fwd_dir: got %b want 1", forward); end
    for (int i = 0; i < 4; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(exp_d[i])) begin n_fail++; $display("FAIL fwd_ramp[%0d]: got %0d want %0d", i, duty, exp_d[i]); end
    end
  endtask

  task automatic test_reversal;
    int exp_dn[3] = '{150, 50, 0};
    int exp_up[3] = '{100, 200, 300};
    send_cmd(-300);
    for (int i = 0; i < 3; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(exp_dn[i]) || state !== 2'b10 || forward !== 1'b1) begin
        n_fail++; $display("FAIL rev_down[%0d]: duty=%0d state=%b fwd=%b want %0d/10/1", i, duty, state, forward, exp_dn[i]);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 2'b11 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL rev_enter_dead: state=%b ready=%b want 11/0", state, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick;
      n_checks++;
      if (state !== 2'b11 || duty !== 10'd0 || forward !== 1'b1 || cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL rev_dead[%0d]: state=%b duty=%0d fwd=%b ready=%b want 11/0/1/0", i, state, duty, forward, cmd_ready);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 2'b01 || forward !== 1'b0) begin
      n_fail++; $display("FAIL rev_exit_dead: state=%b fwd=%b want 01/0", state, forward);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(exp_up[i]) || forward !== 1'b0) begin
        n_fail++; $display("FAIL rev_up[%0d]: duty=%0d fwd=%b want %0d/0", i, duty, forward, exp_up[i]);
      end
    end
  endtask

  task automatic test_reverse_abort;
    int exp_d[3] = '{300, 400, 400};
    send_cmd(400);
    wait_tick;
    n_checks++;
    if (duty !== 10'd200 || state !== 2'b10 || forward !== 1'b0) begin
      n_fail++; $display("FAIL abort_rev: duty=%0d state=%b fwd=%b want 200/10/0", duty, state, forward);
    end
    send_cmd(-400);
    @(posedge clk); #1;
    n_checks++;
    if (state !== 2'b01 || forward !== 1'b0) begin
      n_fail++; $display("FAIL abort_run: state=%b fwd=%b want 01/0", state, forward);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(exp_d[i])) begin n_fail++; $display("FAIL abort_ramp[%0d]: got %0d want %0d", i, duty, exp_d[i]); end
    end
  endtask

  task automatic test_saturation;
    int exp_dn[10] = '{850, 750, 650, 550, 450, 350, 250, 150, 50, 0};
    send_cmd(-1000);
    for (int i = 0; i < 6; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(500 + 100 * i)) begin n_fail++; $display("FAIL sat_up[%0d]: got %0d want %0d", i, duty, 500 + 100 * i); end
    end
    send_cmd(-1023);
    wait_tick;
    n_checks++; if (duty !== 10'd1023) begin n_fail++; $display("FAIL sat_top: got %0d want 1023", duty); end
    send_cmd(-1024);
    repeat (2) wait_tick;
    n_checks++;
    if (duty !== 10'd1023 || state !== 2'b01 || forward !== 1'b0) begin
      n_fail++; $display("FAIL sat_neg1024: duty=%0d state=%b fwd=%b want 1023/01/0", duty, state, forward);
    end
    send_cmd(-950);
    wait_tick;
    n_checks++; if (duty !== 10'd950) begin n_fail++; $display("FAIL sat_down_clamp: got %0d want 950", duty); end
    send_cmd(0);
    for (int i = 0; i < 10; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(exp_dn[i])) begin n_fail++; $display("FAIL zero_ramp[%0d]: got %0d want %0d", i, duty, exp_dn[i]); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 2'b00 || busy !== 1'b0 || forward !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle: state=%b busy=%b fwd=%b want 00/0/0", state, busy, forward);
    end
  endtask

  task automatic test_estop;
    send_cmd(600);
    @(posedge clk); #1;
    n_checks++;
    if (state !== 2'b01 || forward !== 1'b1) begin
      n_fail++; $display("FAIL estop_start: state=%b fwd=%b want 01/1", state, forward);
    end
    for (int i = 0; i < 5; i++) begin
      wait_tick;
      n_checks++;
      if (duty !== 10'(100 + 100 * i)) begin n_fail++; $display("FAIL estop_ramp[%0d]: got %0d want %0d", i, duty, 100 + 100 * i); end
    end
    #2 enable = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL estop_ready: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    n_checks++;
    if (duty !== 10'd0 || state !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL estop_stop: duty=%0d state=%b busy=%b want 0/00/0", duty, state, busy);
    end
    cmd_valid = 1'b1; cmd_power = 11'd200;
    repeat (2) wait_tick;
    cmd_valid = 1'b0; cmd_power = 11'd0;
    enable = 1'b1;
    repeat (2) wait_tick;
    n_checks++;
    if (duty !== 10'd0 || state !== 2'b00) begin
      n_fail++; $display("FAIL estop_ignored: duty=%0d state=%b want 0/00", duty, state);
    end
  endtask

  task automatic test_reset_midramp;
    wait_tick;
    send_cmd(800);
    repeat (3) wait_tick;
    n_checks++; if (duty !== 10'd300) begin n_fail++; $display("FAIL midreset_pre: got %0d want 300", duty); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (duty !== 10'd0 || state !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_async: duty=%0d state=%b busy=%b want 0/00/0", duty, state, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_watchdog;
    int exp_d;
    logic exp_t;
    wait_tick;
    send_cmd(300);
    for (int t = 1; t <= 23; t++) begin
      wait_tick;
`ifdef MOTOR_CMD_WDT_EN
      exp_d = (t <= 3) ? 100 * t : (t <= 20) ? 300 : 300 - 100 * (t - 20);
      exp_t = (t >= 20);
`else
      exp_d = (t <= 3) ? 100 * t : 300;
      exp_t = 1'b0;
`endif
      n_checks++;
      if (duty !== 10'(exp_d) || wdt_trip !== exp_t) begin
        n_fail++; $display("FAIL wdt_tick[%0d]: duty=%0d trip=%b want %0d/%b", t, duty, wdt_trip, exp_d, exp_t);
      end
    end
    @(posedge clk); #1;
`ifdef MOTOR_CMD_WDT_EN
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL wdt_idle: state=%b want 00", state); end
`else
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL wdt_hold: state=%b want 01", state); end
`endif
    wait_tick;
    send_cmd(100);
    n_checks++; if (wdt_trip !== 1'b0) begin n_fail++; $display("FAIL wdt_clear: got %b want 0", wdt_trip); end
    wait_tick;
`ifdef MOTOR_CMD_WDT_EN
    exp_d = 100;
`else
    exp_d = 200;
`endif
    n_checks++; if (duty !== 10'(exp_d)) begin n_fail++; $display("FAIL wdt_recmd: got %0d want %0d", duty, exp_d); end
    wait_tick;
    n_checks++; if (duty !== 10'd100) begin n_fail++; $display("FAIL wdt_recmd2: got %0d want 100", duty); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, 0 of 1 expected completions");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_forward_ramp;
    test_reversal;
    test_reverse_abort;
    test_saturation;
    test_estop;
    test_reset_midramp;
    test_watchdog;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_ramp_ctrl.md
MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 Parameter TICK_DIV, 100000, clk cycles per ramp tick (1 ms at 100 MHz); legal range 2..2^24.
REQ-002 Parameter STEP, 16, duty change per ramp tick; legal range 1..1023.
REQ-003 Parameter DEAD_TICKS, 50, ramp ticks held at zero duty before a direction reversal; legal range 1..255.
REQ-004 Parameter WDT_TICKS, 200, ramp ticks without an accepted command before the watchdog trips; legal range 1..65535.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run enable; low = emergency stop.
REQ-008 cmd_valid  input  1  command strobe.
REQ-009 cmd_ready  output  1  command accept; a transfer occurs on a clk edge where cmd_valid and cmd_ready are both high.
REQ-010 cmd_power  input  11  signed two's-complement target power, -1023..+1023; -1024 is treated as -1023.
REQ-011 duty  output  10  PWM duty magnitude for the motor datapath, 0..1023.
REQ-012 forward  output  1  direction: 1 = forward, 0 = backward.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 state  output  2  debug state code: IDLE=00, RUN=01, REVERSE=10, DEAD=11.
REQ-015 wdt_trip  output  1  watchdog-tripped flag.

Function
REQ-016 The prescaler counts 0..TICK_DIV-1 and wraps; tick is high for one cycle when count==TICK_DIV-1.
REQ-017 An accepted command loads tgt_mag=|cmd_power| and tgt_dir=(cmd_power>=0) one cycle after the accept edge; a zero command leaves tgt_dir unchanged.
REQ-018 cmd_ready is high in IDLE, RUN and REVERSE, and low in DEAD.
REQ-019 Duty changes only on tick, with saturating steps: when duty<goal, duty=min(duty+STEP, goal); when duty>goal, duty=max(duty-STEP, goal); duty never wraps.
REQ-020 The goal is tgt_mag in RUN and 0 in REVERSE.
REQ-021 IDLE transitions: when tgt_mag!=0, set forward=tgt_dir immediately and go to RUN.
REQ-022 RUN transitions: when tgt_dir!=forward and tgt_mag!=0, go to REVERSE; when duty==0 and tgt_mag==0, go to IDLE.
REQ-023 REVERSE transitions: when tgt_dir==forward again, return to RUN and resume ramping from the current duty; when duty reaches 0, go to DEAD and clear the dead counter.
REQ-024 DEAD: duty is held at 0; the dead counter increments on each tick; at DEAD_TICKS, toggle forward and go to RUN (or to IDLE if tgt_mag==0).
REQ-025 The forward output never changes while duty!=0.
REQ-026 enable low forces duty=0, state=IDLE and tgt_mag=0 on the next edge, with no ramp; commands are ignored (cmd_ready=0) while enable is low.
REQ-027 When a tick and an accept occur on the same edge, the step uses the old goal and the new target applies from the next tick.

Reset
REQ-028 Asynchronous reset SHALL set duty=0, forward=1, state=IDLE, busy=0, cmd_ready=1, wdt_trip=0, tgt_mag=0, tgt_dir=1, and clear all counters; reset asserted mid-ramp zeroes duty immediately.

Configuration
REQ-029 With MOTOR_CMD_WDT_EN defined, a tick counter is cleared on every accepted command; on reaching WDT_TICKS it forces tgt_mag=0 (normal ramp-down) and sets wdt_trip, which stays high until the next accepted command.
REQ-030 Without MOTOR_CMD_WDT_EN, the watchdog logic is absent, the wdt_trip port remains present and is tied to 0, and the target persists indefinitely.

Verification (TICK_DIV=4, STEP=100, DEAD_TICKS=3, WDT_TICKS=20)
REQ-031 Reset, then enable=1 and cmd +250 -> forward=1; duty 100, 200, 250 on successive ticks; state RUN; busy=1.
REQ-032 At duty 250 forward, cmd -300 -> state REVERSE; duty 150, 50, 0; state DEAD with cmd_ready=0 for 3 ticks; then forward=0 and duty ramps 100, 200, 300.
REQ-033 In REVERSE at duty 150, cmd +400 -> state RUN, forward stays 1, duty 250, 350, 400.
REQ-034 At duty 1000, cmd +1023 with STEP=100 -> duty 1023 (saturates, no wrap); cmd -1024 later -> target magnitude 1023.
REQ-035 At duty 500, enable=0 -> duty=0 and state=IDLE on the next edge; assert reset mid-ramp -> duty=0 asynchronously.
REQ-036 With MOTOR_CMD_WDT_EN, cmd +300 and no further commands -> after 20 ticks wdt_trip=1 and duty ramps to 0 (state IDLE); cmd +100 -> wdt_trip=0. Without the macro, duty holds 300 and wdt_trip stays 0.
